// File: rtl/hazard3_irq_cond.sv
// Per-line external interrupt conditioner: synchronise, optionally invert and
// glitch-filter, then pass through as a level or latch as a sticky edge.
module hazard3_irq_cond #(
    parameter int unsigned         NUM_IRQS      = 32,
    parameter int unsigned         SYNC_STAGES   = 2,
    parameter int unsigned         FILTER_CYCLES = 0,
    parameter logic [NUM_IRQS-1:0] EDGE_MASK     = {NUM_IRQS{1'b0}},
    parameter logic [NUM_IRQS-1:0] INVERT_MASK   = {NUM_IRQS{1'b0}}
) (
    input  logic                clk_always_on,
    input  logic                rst_n,
    input  logic [NUM_IRQS-1:0] irq_in,
    input  logic [NUM_IRQS-1:0] clr,
    output logic [NUM_IRQS-1:0] irq_out,
    output logic [NUM_IRQS-1:0] edge_lost,
    output logic                wakeup
);

    logic [SYNC_STAGES-1:0][NUM_IRQS-1:0] sync_q;
    logic [NUM_IRQS-1:0]                  sync_s;
    logic                                 wakeup_q;

    always_ff @(posedge clk_always_on or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
        end
    end

    // Inversion sits after the synchroniser so reset always clears the flops.
    assign sync_s = sync_q[SYNC_STAGES-1] ^ INVERT_MASK;

    for (genvar i = 0; i < NUM_IRQS; i++) begin : g_line
        logic f_q;

        if (FILTER_CYCLES == 0) begin : g_nofilt
            always_ff @(posedge clk_always_on or negedge rst_n) begin
                if (!rst_n) begin
                    f_q <= 1'b0;
                end else begin
                    f_q <= sync_s[i];
                end
            end
        end else begin : g_filt
            localparam logic [3:0] CNT_MAX = 4'(FILTER_CYCLES - 1);
            logic [3:0] cnt_q;
            logic [3:0] cnt_d;
            logic       f_d;

            // Any sample equal to the accepted level restarts the count.
            always_comb begin
                f_d   = f_q;
                cnt_d = 4'd0;
                if (sync_s[i] != f_q) begin
                    if (cnt_q == CNT_MAX) begin
                        f_d = sync_s[i];
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            always_ff @(posedge clk_always_on or negedge rst_n) begin
                if (!rst_n) begin
                    f_q   <= 1'b0;
                    cnt_q <= 4'd0;
                end else begin
                    f_q   <= f_d;
                    cnt_q <= cnt_d;
                end
            end
        end

        if (EDGE_MASK[i]) begin : g_edge
            logic fp_q;
            logic p_q;
            logic lost_q;
            logic rise;

            assign rise = f_q & ~fp_q;

            // A rise beats a simultaneous clear, and is then not counted as lost.
            always_ff @(posedge clk_always_on or negedge rst_n) begin
                if (!rst_n) begin
                    fp_q   <= 1'b0;
                    p_q    <= 1'b0;
                    lost_q <= 1'b0;
                end else begin
                    fp_q <= f_q;
                    p_q  <= rise | (p_q & ~clr[i]);
                    if (clr[i] && !rise) begin
                        lost_q <= 1'b0;
                    end else if (rise && p_q && !clr[i]) begin
                        lost_q <= 1'b1;
                    end
                end
            end

            assign irq_out[i]   = p_q;
            assign edge_lost[i] = lost_q;
        end else begin : g_level
            logic unused_clr;
            assign unused_clr   = clr[i];
            assign irq_out[i]   = f_q;
            assign edge_lost[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_always_on or negedge rst_n) begin
        if (!rst_n) begin
            wakeup_q <= 1'b0;
        end else begin
            wakeup_q <= |irq_out;
        end
    end

    assign wakeup = wakeup_q;

endmodule

// File: tb/tb_hazard3_irq_cond.sv
// Bench for hazard3_irq_cond: two configurations (unfiltered and filtered)
// driven in parallel and compared each cycle against a window-based model.
module tb_hazard3_irq_cond;

    localparam int W = 8;
    localparam int SS_A = 2;
    localparam int N_A  = 0;
    localparam logic [W-1:0] EM_A = 8'h60;
    localparam logic [W-1:0] IM_A = 8'h00;
    localparam int SS_B = 3;
    localparam int N_B  = 4;
    localparam logic [W-1:0] EM_B = 8'h60;
    localparam logic [W-1:0] IM_B = 8'h80;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] irq_in = '0;
    logic [W-1:0] clr = '0;
    logic [W-1:0] out_a, lost_a, out_b, lost_b;
    logic         wake_a, wake_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard3_irq_cond #(
        .NUM_IRQS(W), .SYNC_STAGES(SS_A), .FILTER_CYCLES(N_A),
        .EDGE_MASK(EM_A), .INVERT_MASK(IM_A)
    ) u_dut_a (
        .clk_always_on(clk), .rst_n(rst_n), .irq_in(irq_in), .clr(clr),
        .irq_out(out_a), .edge_lost(lost_a), .wakeup(wake_a)
    );

    hazard3_irq_cond #(
        .NUM_IRQS(W), .SYNC_STAGES(SS_B), .FILTER_CYCLES(N_B),
        .EDGE_MASK(EM_B), .INVERT_MASK(IM_B)
    ) u_dut_b (
        .clk_always_on(clk), .rst_n(rst_n), .irq_in(irq_in), .clr(clr),
        .irq_out(out_b), .edge_lost(lost_b), .wakeup(wake_b)
    );

    // Model state, index 0 = config A, 1 = config B.
    logic [W-1:0] m_sync [2][4];
    logic [W-1:0] m_win  [2][16];
    int           m_nsamp [2];
    logic [W-1:0] m_f [2];
    logic [W-1:0] m_fp [2];
    logic [W-1:0] m_p [2];
    logic [W-1:0] m_lost [2];
    logic         m_wake [2];

    function automatic logic [W-1:0] m_out(input int c);
        logic [W-1:0] em;
        em = (c == 0) ? EM_A : EM_B;
        return (m_f[c] & ~em) | (m_p[c] & em);
    endfunction

    task automatic model_step(input int c);
        int           ss, n;
        logic [W-1:0] em, im, s_now, rise, f_new;
        logic         all_diff;
        ss = (c == 0) ? SS_A : SS_B;
        n  = (c == 0) ? N_A : N_B;
        em = (c == 0) ? EM_A : EM_B;
        im = (c == 0) ? IM_A : IM_B;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) m_sync[c][k] = '0;
            for (int k = 0; k < 16; k++) m_win[c][k] = '0;
            m_nsamp[c] = 0;
            m_f[c] = '0;
            m_fp[c] = '0;
            m_p[c] = '0;
            m_lost[c] = '0;
            m_wake[c] = 1'b0;
        end else begin
            s_now = m_sync[c][ss-1] ^ im;
            for (int k = 15; k > 0; k--) m_win[c][k] = m_win[c][k-1];
            m_win[c][0] = s_now;
            if (m_nsamp[c] < 16) m_nsamp[c]++;
            m_wake[c] = |m_out(c);
            rise = m_f[c] & ~m_fp[c] & em;
            for (int i = 0; i < W; i++) begin
                if (clr[i] && !rise[i]) m_lost[c][i] = 1'b0;
                else if (rise[i] && m_p[c][i] && !clr[i]) m_lost[c][i] = 1'b1;
            end
            m_lost[c] = m_lost[c] & em;
            m_p[c] = (rise | (m_p[c] & ~clr)) & em;
            // Accept a new level once the last n samples all disagree with the current one.
            f_new = m_f[c];
            if (n == 0) begin
                f_new = s_now;
            end else if (m_nsamp[c] >= n) begin
                for (int i = 0; i < W; i++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < n; j++)
                        if (m_win[c][j][i] == m_f[c][i]) all_diff = 1'b0;
                    if (all_diff) f_new[i] = ~m_f[c][i];
                end
            end
            m_fp[c] = m_f[c];
            m_f[c] = f_new;
            for (int k = 3; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
            m_sync[c][0] = irq_in;
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        chk("model_out_a", out_a, m_out(0));
        chk("model_lost_a", lost_a, m_lost[0]);
        chk("model_wake_a", {7'd0, wake_a}, {7'd0, m_wake[0]});
        chk("model_out_b", out_b, m_out(1));
        chk("model_lost_b", lost_b, m_lost[1]);
        chk("model_wake_b", {7'd0, wake_b}, {7'd0, m_wake[1]});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic random_phase(input int cycles);
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 5) == 0) irq_in[i] = ~irq_in[i];
                clr[i] = ($urandom_range(0, 7) == 0);
            end
        end
        @(negedge clk);
        clr = '0;
    endtask

    initial begin
        tick(3);
        chk("rst_out_b", out_b, 8'h00);
        chk("rst_out_a", out_a, 8'h00);
        rst_n = 1'b1;

        // Inverted line held low becomes active once the filter accepts it.
        tick(3);
        chk("inv7_early", {7'd0, out_b[7]}, 8'd0);
        tick(1);
        chk("inv7_set", {7'd0, out_b[7]}, 8'd1);

        // Level line 3, unfiltered.
        irq_in[3] = 1'b1;
        tick(2);
        chk("lvl_early", {7'd0, out_a[3]}, 8'd0);
        tick(1);
        chk("lvl_rise", {7'd0, out_a[3]}, 8'd1);
        chk("wake_early", {7'd0, wake_a}, 8'd0);
        tick(1);
        chk("wake_set", {7'd0, wake_a}, 8'd1);
        tick(6);
        irq_in[3] = 1'b0;
        tick(2);
        chk("lvl_hold", {7'd0, out_a[3]}, 8'd1);
        tick(1);
        chk("lvl_fall", {7'd0, out_a[3]}, 8'd0);
        tick(1);
        chk("wake_clear", {7'd0, wake_a}, 8'd0);

        // Filtered level line 0: short pulse rejected, long accepted, glitch ignored.
        irq_in[0] = 1'b1;
        tick(3);
        irq_in[0] = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick(1);
            chk("filt_short", {7'd0, out_b[0]}, 8'd0);
        end
        irq_in[0] = 1'b1;
        tick(6);
        chk("filt_early", {7'd0, out_b[0]}, 8'd0);
        tick(1);
        chk("filt_rise", {7'd0, out_b[0]}, 8'd1);
        irq_in[0] = 1'b0;
        tick(1);
        irq_in[0] = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick(1);
            chk("filt_glitch", {7'd0, out_b[0]}, 8'd1);
        end
        irq_in[0] = 1'b0;
        tick(10);

        // Edge line 5: latch, hold after source drops, clear.
        irq_in[5] = 1'b1;
        tick(3);
        chk("edge_early", {7'd0, out_a[5]}, 8'd0);
        tick(1);
        chk("edge_set", {7'd0, out_a[5]}, 8'd1);
        irq_in[5] = 1'b0;
        tick(10);
        chk("edge_hold", {7'd0, out_a[5]}, 8'd1);
        clr[5] = 1'b1;
        tick(1);
        clr[5] = 1'b0;
        chk("edge_clr", {7'd0, out_a[5]}, 8'd0);

        // Pending, then a rise coincident with clr: set wins, nothing lost.
        irq_in[5] = 1'b1;
        tick(4);
        irq_in[5] = 1'b0;
        tick(6);
        chk("edge_pend", {7'd0, out_a[5]}, 8'd1);
        irq_in[5] = 1'b1;
        tick(3);
        clr[5] = 1'b1;
        tick(1);
        clr[5] = 1'b0;
        irq_in[5] = 1'b0;
        chk("setwins_out", {7'd0, out_a[5]}, 8'd1);
        chk("setwins_lost", {7'd0, lost_a[5]}, 8'd0);
        tick(6);

        // Second rise while pending sets edge_lost; a plain clr clears both.
        irq_in[5] = 1'b1;
        tick(4);
        irq_in[5] = 1'b0;
        tick(6);
        chk("lost_set", {7'd0, lost_a[5]}, 8'd1);
        chk("lost_out", {7'd0, out_a[5]}, 8'd1);
        clr[5] = 1'b1;
        tick(1);
        clr[5] = 1'b0;
        chk("lost_clr_out", {7'd0, out_a[5]}, 8'd0);
        chk("lost_clr_lost", {7'd0, lost_a[5]}, 8'd0);
        tick(4);

        random_phase(2000);

        // Reset in the middle of a filter count.
        irq_in = '0;
        tick(20);
        irq_in[0] = 1'b1;
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_a", out_a, 8'h00);
        chk("midrst_out_b", out_b, 8'h00);
        chk("midrst_lost_a", lost_a, 8'h00);
        chk("midrst_wake", {6'd0, wake_a, wake_b}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("midrst_refilt_early", {7'd0, out_b[0]}, 8'd0);
        tick(1);
        chk("midrst_refilt_rise", {7'd0, out_b[0]}, 8'd1);

        random_phase(300);
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
